// File: rtl/clk_div_monitor_pkg.sv
// Shared types and defaults for the divided-clock monitor and its bench.
package clk_div_monitor_pkg;

   localparam int unsigned CNT_W_DEF   = 8;
   localparam int unsigned TIMEOUT_DEF = 255;
   localparam int unsigned STAT_W      = 8;

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_e;

   // Status counters stick at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] sat_inc_stat(input logic [STAT_W-1:0] v);
      return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/clk_div_monitor_if.sv
// Expectation inputs and measurement/status outputs of the divided-clock monitor.
interface clk_div_monitor_if
   import clk_div_monitor_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
);
   logic              sig_in;
   logic [CNT_W-1:0]  exp_high;
   logic [CNT_W-1:0]  exp_low;
   logic [CNT_W-1:0]  high_len;
   logic [CNT_W-1:0]  low_len;
   logic [CNT_W:0]    period;
   logic              meas_valid;
   logic              match;
   logic [STAT_W-1:0] err_count;
   logic [STAT_W-1:0] edge_count;
   logic              stuck;

   modport master (
      output sig_in, exp_high, exp_low,
      input  high_len, low_len, period, meas_valid, match, err_count, edge_count, stuck
   );

   modport slave (
      input  sig_in, exp_high, exp_low,
      output high_len, low_len, period, meas_valid, match, err_count, edge_count, stuck
   );
endinterface

// File: rtl/clk_div_monitor_edge_detect_sync.sv
// Two-flop sampler of an asynchronous-looking level with rise/fall strobes.
module edge_detect_sync (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic rise_c,
   output logic fall_c
);
   logic sig_q, sig_d;
   logic sig_q2, sig2_d;

   always_comb begin
      sig_d  = sig_in;
      sig2_d = sig_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q  <= 1'b0;
         sig_q2 <= 1'b0;
      end else begin
         sig_q  <= sig_d;
         sig_q2 <= sig2_d;
      end
   end

   assign rise_c = sig_q & ~sig_q2;
   assign fall_c = ~sig_q & sig_q2;
endmodule

// File: rtl/clk_div_monitor.sv
// Measures high/low/period of a divided clock sampled in the clk_in domain and
// checks each complete period against the programmed expectations.
module clk_div_monitor
   import clk_div_monitor_pkg::*;
#(
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF,
   parameter int unsigned TOL     = 0
) (
   input  logic             clk_in,
   input  logic             rst,
   clk_div_monitor_if.slave mon
);
   localparam int unsigned      PER_W     = CNT_W + 1;
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   logic rise_c, fall_c, match_c;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0]  high_len_q, high_len_d;
   logic [CNT_W-1:0]  low_len_q, low_len_d;
   logic [PER_W-1:0]  period_q, period_d;
   logic              meas_valid_q, meas_valid_d;
   logic              match_q, match_d;
   logic [STAT_W-1:0] err_count_q, err_count_d;
   logic [STAT_W-1:0] edge_count_q, edge_count_d;
   logic              stuck_q, stuck_d;

   edge_detect_sync u_edge (
      .clk    (clk_in),
      .rst    (rst),
      .sig_in (mon.sig_in),
      .rise_c (rise_c),
      .fall_c (fall_c)
   );

   function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   // The running count is the low length of the period closing this cycle.
   assign match_c = (abs_diff(high_len_q, mon.exp_high) <= TOL_C) &&
                    (abs_diff(run_cnt_q, mon.exp_low) <= TOL_C);

   always_comb begin
      state_d      = state_q;
      run_cnt_d    = run_cnt_q;
      high_len_d   = high_len_q;
      low_len_d    = low_len_q;
      period_d     = period_q;
      meas_valid_d = 1'b0;
      match_d      = match_q;
      err_count_d  = err_count_q;
      edge_count_d = edge_count_q;
      stuck_d      = stuck_q;

      unique case (state_q)
         ST_SYNC: begin
            if (rise_c) begin
               state_d      = ST_HIGH;
               run_cnt_d    = ONE_C;
               edge_count_d = sat_inc_stat(edge_count_q);
            end
         end
         ST_HIGH: begin
            if (fall_c) begin
               high_len_d = run_cnt_q;
               run_cnt_d  = ONE_C;
               state_d    = ST_LOW;
            end else if (run_cnt_q == TIMEOUT_C) begin
               stuck_d   = 1'b1;
               run_cnt_d = '0;
               state_d   = ST_SYNC;
            end else begin
               run_cnt_d = run_cnt_q + ONE_C;
            end
         end
         ST_LOW: begin
            if (rise_c) begin
               low_len_d    = run_cnt_q;
               period_d     = PER_W'(high_len_q) + PER_W'(run_cnt_q);
               meas_valid_d = 1'b1;
               match_d      = match_c;
               edge_count_d = sat_inc_stat(edge_count_q);
               if (!match_c) err_count_d = sat_inc_stat(err_count_q);
               run_cnt_d    = ONE_C;
               state_d      = ST_HIGH;
            end else if (run_cnt_q == TIMEOUT_C) begin
               stuck_d   = 1'b1;
               run_cnt_d = '0;
               state_d   = ST_SYNC;
            end else begin
               run_cnt_d = run_cnt_q + ONE_C;
            end
         end
         default: begin
            state_d   = ST_SYNC;
            run_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q      <= ST_SYNC;
         run_cnt_q    <= '0;
         high_len_q   <= '0;
         low_len_q    <= '0;
         period_q     <= '0;
         meas_valid_q <= 1'b0;
         match_q      <= 1'b0;
         err_count_q  <= '0;
         edge_count_q <= '0;
         stuck_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         run_cnt_q    <= run_cnt_d;
         high_len_q   <= high_len_d;
         low_len_q    <= low_len_d;
         period_q     <= period_d;
         meas_valid_q <= meas_valid_d;
         match_q      <= match_d;
         err_count_q  <= err_count_d;
         edge_count_q <= edge_count_d;
         stuck_q      <= stuck_d;
      end
   end

   assign mon.high_len   = high_len_q;
   assign mon.low_len    = low_len_q;
   assign mon.period     = period_q;
   assign mon.meas_valid = meas_valid_q;
   assign mon.match      = match_q;
   assign mon.err_count  = err_count_q;
   assign mon.edge_count = edge_count_q;
   assign mon.stuck      = stuck_q;
endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomised run-length stimulus for two monitors (TOL 0 and 1) checked by a
// scoreboard fed from a run-length reference model.
module tb_clk_div_monitor;
   import clk_div_monitor_pkg::*;

   localparam int TMO = int'(TIMEOUT_DEF);

   typedef struct {
      int h;
      int l;
      int p;
      int m;
      int err;
      int edge_n;
   } meas_t;

   logic clk_in = 1'b0;
   logic rst    = 1'b1;

   clk_div_monitor_if #(.CNT_W(CNT_W_DEF)) mon0 ();
   clk_div_monitor_if #(.CNT_W(CNT_W_DEF)) mon1 ();

   clk_div_monitor #(.CNT_W(CNT_W_DEF), .TIMEOUT(TIMEOUT_DEF), .TOL(0)) dut0 (
      .clk_in (clk_in),
      .rst    (rst),
      .mon    (mon0)
   );

   clk_div_monitor #(.CNT_W(CNT_W_DEF), .TIMEOUT(TIMEOUT_DEF), .TOL(1)) dut1 (
      .clk_in (clk_in),
      .rst    (rst),
      .mon    (mon1)
   );

   always #5 clk_in = ~clk_in;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   // Reference model: whole runs of the sampled level.
   meas_t q0[$];
   meas_t q1[$];
   bit cur_level = 1'b0;
   int cur_len   = 1;
   int phase     = 0;   // 0 unlocked, 1 inside high run, 2 inside low run
   int last_h    = 0;
   int edge_m    = 0;
   int err0      = 0;
   int err1      = 0;
   int stuck_m   = 0;
   int cur_eh    = 0;
   int cur_el    = 0;
   int pend_eh   = 0;
   int pend_el   = 0;

   int stuck_seen = 0;
   int stuck_cyc  = -1;

   task automatic chk(input string name, input int act, input int exp_v);
      vectors++;
      if (act != exp_v) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   function automatic int absd(input int a, input int b);
      return (a >= b) ? a - b : b - a;
   endfunction

   function automatic void end_run(input bit lvl, input int n);
      int m0, m1;
      if (lvl) begin
         if (phase == 1) begin
            if (n > TMO) begin
               stuck_m = 1;
               phase   = 0;
            end else begin
               last_h = n;
               phase  = 2;
            end
         end
      end else begin
         if (edge_m < 255) edge_m++;
         if (phase == 2 && n <= TMO) begin
            m0 = (absd(last_h, cur_eh) <= 0 && absd(n, cur_el) <= 0) ? 1 : 0;
            m1 = (absd(last_h, cur_eh) <= 1 && absd(n, cur_el) <= 1) ? 1 : 0;
            if (m0 == 0 && err0 < 255) err0++;
            if (m1 == 0 && err1 < 255) err1++;
            q0.push_back('{h: last_h, l: n, p: last_h + n, m: m0, err: err0, edge_n: edge_m});
            q1.push_back('{h: last_h, l: n, p: last_h + n, m: m1, err: err1, edge_n: edge_m});
         end else if (phase == 2) begin
            stuck_m = 1;
         end
         phase = 1;
      end
   endfunction

   // One sample period of stimulus; expectations move only when no compare is in flight.
   task automatic step(input bit lvl);
      @(negedge clk_in);
      if (!(cur_level && cur_len == 1)) begin
         cur_eh = pend_eh;
         cur_el = pend_el;
      end
      mon0.exp_high = CNT_W_DEF'(cur_eh);
      mon0.exp_low  = CNT_W_DEF'(cur_el);
      mon1.exp_high = CNT_W_DEF'(cur_eh);
      mon1.exp_low  = CNT_W_DEF'(cur_el);
      mon0.sig_in   = lvl;
      mon1.sig_in   = lvl;
      if (lvl != cur_level) begin
         end_run(cur_level, cur_len);
         cur_level = lvl;
         cur_len   = 1;
      end else begin
         cur_len++;
      end
   endtask

   task automatic drive_period(input int h, input int l);
      repeat (h) step(1'b1);
      repeat (l) step(1'b0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_high_len0"}, int'(mon0.high_len), 0);
      chk({tag, "_low_len0"},  int'(mon0.low_len), 0);
      chk({tag, "_period0"},   int'(mon0.period), 0);
      chk({tag, "_valid0"},    int'(mon0.meas_valid), 0);
      chk({tag, "_match0"},    int'(mon0.match), 0);
      chk({tag, "_err0"},      int'(mon0.err_count), 0);
      chk({tag, "_edge0"},     int'(mon0.edge_count), 0);
      chk({tag, "_stuck0"},    int'(mon0.stuck), 0);
      chk({tag, "_state0"},    int'(dut0.state_q), int'(ST_SYNC));
      chk({tag, "_edge1"},     int'(mon1.edge_count), 0);
      chk({tag, "_match1"},    int'(mon1.match), 0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk_in);
      rst         = 1'b1;
      mon0.sig_in = 1'b0;
      mon1.sig_in = 1'b0;
      @(negedge clk_in);
      check_zero(tag);
      rst       = 1'b0;
      cur_level = 1'b0;
      cur_len   = 1;
      phase     = 0;
      edge_m    = 0;
      err0      = 0;
      err1      = 0;
      stuck_m   = 0;
   endtask

   task automatic check_status(input string tag);
      repeat (3) step(cur_level);
      chk({tag, "_edge0"},  int'(mon0.edge_count), edge_m);
      chk({tag, "_err0"},   int'(mon0.err_count), err0);
      chk({tag, "_err1"},   int'(mon1.err_count), err1);
      chk({tag, "_stuck0"}, int'(mon0.stuck), stuck_m);
      chk({tag, "_stuck1"}, int'(mon1.stuck), stuck_m);
      chk({tag, "_pending0"}, q0.size(), 0);
      chk({tag, "_pending1"}, q1.size(), 0);
   endtask

   task automatic cmp_meas(input string tag, input meas_t e, input int h, input int l,
                           input int p, input int m, input int err, input int edge_n);
      chk({tag, "_high_len"},   h, e.h);
      chk({tag, "_low_len"},    l, e.l);
      chk({tag, "_period"},     p, e.p);
      chk({tag, "_match"},      m, e.m);
      chk({tag, "_err_count"},  err, e.err);
      chk({tag, "_edge_count"}, edge_n, e.edge_n);
   endtask

   // Scoreboard monitors: pop one expectation per meas_valid pulse.
   meas_t e0, e1;
   always @(negedge clk_in) begin
      if (mon0.meas_valid) begin
         if (q0.size() == 0) chk("dut0_unexpected_meas_valid", 1, 0);
         else begin
            e0 = q0.pop_front();
            cmp_meas("dut0", e0, int'(mon0.high_len), int'(mon0.low_len), int'(mon0.period),
                     int'(mon0.match), int'(mon0.err_count), int'(mon0.edge_count));
         end
      end
      if (mon0.stuck && stuck_seen == 0) begin
         stuck_seen = 1;
         stuck_cyc  = cyc;
      end
   end

   always @(negedge clk_in) begin
      if (mon1.meas_valid) begin
         if (q1.size() == 0) chk("dut1_unexpected_meas_valid", 1, 0);
         else begin
            e1 = q1.pop_front();
            cmp_meas("dut1", e1, int'(mon1.high_len), int'(mon1.low_len), int'(mon1.period),
                     int'(mon1.match), int'(mon1.err_count), int'(mon1.edge_count));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      mon0.sig_in = 1'b0;   mon1.sig_in = 1'b0;
      mon0.exp_high = '0;   mon0.exp_low = '0;
      mon1.exp_high = '0;   mon1.exp_low = '0;

      do_reset("reset");

      // Low forever from reset: never locks, timeout not armed.
      repeat (300) step(1'b0);
      chk("idle_state", int'(dut0.state_q), int'(ST_SYNC));
      chk("idle_edge",  int'(mon0.edge_count), 0);
      chk("idle_stuck", int'(mon0.stuck), 0);

      pend_eh = 2; pend_el = 2;
      repeat (6) drive_period(2, 2);
      check_status("div4");

      pend_eh = 13; pend_el = 13;
      repeat (5) drive_period(13, 13);
      check_status("div26");

      pend_eh = 1; pend_el = 1;
      repeat (8) drive_period(1, 1);
      check_status("div2");

      repeat (6) drive_period(1, 2);
      check_status("div3");

      for (int i = 0; i < 40; i++) begin
         int h, l;
         h = int'($urandom_range(1, 12));
         l = int'($urandom_range(1, 12));
         pend_eh = ($urandom_range(0, 1) == 1) ? h : int'($urandom_range(1, 12));
         pend_el = ($urandom_range(0, 1) == 1) ? l : int'($urandom_range(1, 12));
         drive_period(h, l);
      end
      check_status("random");

      // Stuck high after lock, then resume toggling.
      pend_eh = 2; pend_el = 2;
      repeat (3) drive_period(2, 2);
      step(1'b1);
      t0 = cyc;
      repeat (299) step(1'b1);
      chk("stuck_latency", stuck_cyc, t0 + 257);
      chk("stuck_state", int'(dut0.state_q), int'(ST_SYNC));
      repeat (2) step(1'b0);
      repeat (4) drive_period(2, 2);
      check_status("resume");

      // Reset in the middle of a low phase.
      repeat (3) drive_period(3, 3);
      repeat (4) step(1'b0);
      do_reset("midlow_reset");
      repeat (3) step(1'b0);
      repeat (4) drive_period(3, 3);
      check_status("after_reset");

      // Saturate both status counters with persistent mismatches.
      pend_eh = 5; pend_el = 5;
      repeat (260) drive_period(1, 2);
      check_status("saturate");
      chk("sat_err0",  int'(mon0.err_count), 255);
      chk("sat_edge0", int'(mon0.edge_count), 255);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
